// File: rtl/imem_responder_pkg.sv
// Shared widths, FSM encoding and defaults for the instruction-memory responder.
package imem_responder_pkg;

    localparam int unsigned ADDR_SIZE  = 31;
    localparam int unsigned INSTR_SIZE = 31;

    localparam logic [INSTR_SIZE:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef logic [ADDR_SIZE:0]   addr_t;
    typedef logic [INSTR_SIZE:0]  instr_t;
    typedef logic [ADDR_SIZE-2:0] word_idx_t;

    typedef enum logic [1:0] {
        ImemIdle = 2'd0,
        ImemWait = 2'd1,
        ImemResp = 2'd2,
        ImemGap  = 2'd3
    } imem_state_e;

    // Depth is a power of two, so an index is in range iff no bit at or above log2(depth) is set.
    function automatic logic idx_in_range(word_idx_t idx, int unsigned aw);
        return (idx >> aw) == '0;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch read port and boot-loader write port of the instruction memory.
// mem_rd_err exists only when IMEM_ERR_EN is defined.
interface imem_responder_if;
    import imem_responder_pkg::*;

    addr_t  mem_rd_addr;
    logic   mem_rd_enable;
    instr_t mem_rd_data;
    logic   mem_rd_ready;
`ifdef IMEM_ERR_EN
    logic   mem_rd_err;
`endif
    logic   ld_wr_en;
    addr_t  ld_wr_addr;
    instr_t ld_wr_data;

`ifdef IMEM_ERR_EN
    modport master (
        output mem_rd_addr, mem_rd_enable, ld_wr_en, ld_wr_addr, ld_wr_data,
        input  mem_rd_data, mem_rd_ready, mem_rd_err
    );
    modport slave (
        input  mem_rd_addr, mem_rd_enable, ld_wr_en, ld_wr_addr, ld_wr_data,
        output mem_rd_data, mem_rd_ready, mem_rd_err
    );
`else
    modport master (
        output mem_rd_addr, mem_rd_enable, ld_wr_en, ld_wr_addr, ld_wr_data,
        input  mem_rd_data, mem_rd_ready
    );
    modport slave (
        input  mem_rd_addr, mem_rd_enable, ld_wr_en, ld_wr_addr, ld_wr_data,
        output mem_rd_data, mem_rd_ready
    );
`endif

endinterface

// File: rtl/imem_array.sv
// Program store: DEPTH_WORDS x 32 words, synchronous write, asynchronous read, never reset.
module imem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory slave: latches a fetch request, waits LATENCY cycles, returns one word.
// Define IMEM_ERR_EN to add the mem_rd_err out-of-range flag.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter instr_t      NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    imem_responder_if.slave bus
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    imem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    addr_t       addr_q, addr_d;
    instr_t      data_q, data_d;
    logic        capture;

    addr_t     rd_addr;
    word_idx_t rd_word, ld_word;
    logic      rd_in_range, ld_in_range;
    instr_t    arr_rd_data;
    logic      unused_lsbs;

    // With LATENCY==1 the capture happens in IDLE, so the live address feeds the array.
    assign rd_addr     = (state_q == ImemIdle) ? bus.mem_rd_addr : addr_q;
    assign rd_word     = rd_addr[ADDR_SIZE:2];
    assign ld_word     = bus.ld_wr_addr[ADDR_SIZE:2];
    assign rd_in_range = idx_in_range(rd_word, AW);
    assign ld_in_range = idx_in_range(ld_word, AW);
    assign unused_lsbs = ^{rd_addr[1:0], bus.ld_wr_addr[1:0]};

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (bus.ld_wr_en & ld_in_range),
        .wr_idx  (ld_word[AW-1:0]),
        .wr_data (bus.ld_wr_data),
        .rd_idx  (rd_word[AW-1:0]),
        .rd_data (arr_rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        capture = 1'b0;
        unique case (state_q)
            ImemIdle: begin
                if (bus.mem_rd_enable) begin
                    addr_d = bus.mem_rd_addr;
                    cnt_d  = CNT_INIT;
                    if (LATENCY == 1) begin
                        capture = 1'b1;
                        state_d = ImemResp;
                    end else begin
                        state_d = ImemWait;
                    end
                end
            end
            ImemWait: begin
                if (!bus.mem_rd_enable) begin
                    state_d = ImemIdle;
                end else if (cnt_q == 4'd1) begin
                    capture = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ImemResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ImemResp: state_d = ImemGap;
            ImemGap:  state_d = ImemIdle;
            default:  state_d = ImemIdle;
        endcase
        data_d = capture ? (rd_in_range ? arr_rd_data : NOP_INSTR) : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ImemIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.mem_rd_ready = (state_q == ImemResp);
    assign bus.mem_rd_data  = data_q;

`ifdef IMEM_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (capture) begin
            err_q <= !rd_in_range;
        end
    end

    assign bus.mem_rd_err = (state_q == ImemResp) & err_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Randomised scoreboard bench: two responders (LATENCY 2 and 1) share one loader port.
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int unsigned DEPTH = 64;

    typedef struct {
        instr_t data;
        logic   err;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   rd_en   [2];
    addr_t  rd_addr [2];
    logic   ld_en;
    addr_t  ld_addr;
    instr_t ld_data;
    logic   rdy     [2];
    instr_t rdata   [2];
    logic   rerr    [2];

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     ready_cyc [2];
    instr_t held  [2];
    instr_t model [DEPTH];
    exp_t   q0[$];
    exp_t   q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_responder_if bus0 ();
    imem_responder_if bus1 ();

    assign bus0.mem_rd_enable = rd_en[0];
    assign bus0.mem_rd_addr   = rd_addr[0];
    assign bus1.mem_rd_enable = rd_en[1];
    assign bus1.mem_rd_addr   = rd_addr[1];
    assign bus0.ld_wr_en      = ld_en;
    assign bus0.ld_wr_addr    = ld_addr;
    assign bus0.ld_wr_data    = ld_data;
    assign bus1.ld_wr_en      = ld_en;
    assign bus1.ld_wr_addr    = ld_addr;
    assign bus1.ld_wr_data    = ld_data;
    assign rdy[0]   = bus0.mem_rd_ready;
    assign rdy[1]   = bus1.mem_rd_ready;
    assign rdata[0] = bus0.mem_rd_data;
    assign rdata[1] = bus1.mem_rd_data;
`ifdef IMEM_ERR_EN
    assign rerr[0] = bus0.mem_rd_err;
    assign rerr[1] = bus1.mem_rd_err;
`else
    assign rerr[0] = 1'b0;
    assign rerr[1] = 1'b0;
`endif

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    function automatic int lat_of(input int w);
        return (w == 0) ? 2 : 1;
    endfunction

    function automatic bit in_range(input addr_t a);
        return (a >> 2) < DEPTH;
    endfunction

    function automatic exp_t expect_of(input addr_t a);
        exp_t e;
        e.err  = !in_range(a);
        e.data = e.err ? 32'h0000_0013 : model[(a >> 2) % DEPTH];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int w);
        exp_t e;
        bit   empty;
        if (reset) begin
            held[w] = '0;
        end else if (rdy[w]) begin
            empty = (w == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                check($sformatf("unexpected_ready%0d", w), {31'b0, rdy[w]}, 32'd0);
            end else begin
                e = (w == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("rd_data%0d", w), rdata[w], e.data);
`ifdef IMEM_ERR_EN
                check($sformatf("rd_err%0d", w), {31'b0, rerr[w]}, {31'b0, e.err});
`endif
                held[w] = e.data;
            end
        end else begin
            check($sformatf("hold%0d", w), rdata[w], held[w]);
`ifdef IMEM_ERR_EN
            check($sformatf("err_idle%0d", w), {31'b0, rerr[w]}, 32'd0);
`endif
        end
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    task automatic ld_write(input addr_t a, input instr_t d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        if (in_range(a)) model[a >> 2] = d;
    endtask

    // Issue one read; optionally drive a loader write to the same word in the capture cycle.
    task automatic fetch(input int w, input addr_t a, input bit wr_cap, input instr_t wr_word,
                         input bit scramble);
        int   lat = lat_of(w);
        int   n   = 0;
        exp_t e   = expect_of(a);
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
        rd_addr[w] = a;
        rd_en[w]   = 1'b1;
        if (wr_cap && lat == 1) begin
            ld_en = 1'b1; ld_addr = a; ld_data = wr_word;
        end
        do begin
            @(posedge clk);
            n++;
            #1;
            if (wr_cap && n == lat - 1) begin
                ld_en = 1'b1; ld_addr = a; ld_data = wr_word;
            end
            if (wr_cap && n == lat) ld_en = 1'b0;
            if (scramble) rd_addr[w] = $urandom;
            @(negedge clk);
        end while (!rdy[w] && n < 20);
        check($sformatf("latency%0d", w), n, lat);
        ready_cyc[w] = cyc;
        rd_en[w] = 1'b0;
        ld_en    = 1'b0;
        if (wr_cap && in_range(a)) model[a >> 2] = wr_word;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    prev;
        addr_t a;
        reset      = 1'b1;
        rd_en[0]   = 1'b0;
        rd_en[1]   = 1'b0;
        rd_addr[0] = '0;
        rd_addr[1] = '0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check("reset_ready", {31'b0, rdy[w]}, 32'd0);
            check("reset_data", rdata[w], 32'd0);
        end
        @(posedge clk);
        #1;

        // Preload every word, then an out-of-range write that would alias word 5 if not dropped.
        for (int i = 0; i < DEPTH; i++) ld_write(addr_t'(i * 4) | addr_t'($urandom_range(0, 3)),
                                                 $urandom);
        ld_write(addr_t'((DEPTH + 5) * 4), ~model[5]);
        fetch(0, 32'h14, 1'b0, '0, 1'b0);

        ld_write(32'h0, 32'hDEAD_BEEF);
        fetch(0, 32'h0, 1'b0, '0, 1'b0);

        // Back-to-back on the single-cycle responder: pulses LATENCY+2 apart.
        fetch(1, 32'h0, 1'b0, '0, 1'b0);
        prev = ready_cyc[1];
        fetch(1, 32'h4, 1'b0, '0, 1'b0);
        check("spacing_a", ready_cyc[1] - prev, 3);
        prev = ready_cyc[1];
        fetch(1, 32'h8, 1'b0, '0, 1'b0);
        check("spacing_b", ready_cyc[1] - prev, 3);

        // Flush: enable dropped in WAIT must produce no ready.
        rd_addr[0] = 32'h4;
        rd_en[0]   = 1'b1;
        @(posedge clk);
        #1;
        rd_en[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        fetch(0, 32'h8, 1'b0, '0, 1'b0);

        for (int w = 0; w < 2; w++) begin
            fetch(w, addr_t'(DEPTH * 4), 1'b0, '0, 1'b0);
            fetch(w, 32'hFFFF_FFFC, 1'b0, '0, 1'b1);
        end

        // Loader write colliding with data capture returns the old word.
        fetch(0, 32'hC, 1'b1, 32'h1111_1111, 1'b0);
        fetch(0, 32'hC, 1'b0, '0, 1'b0);
        fetch(1, 32'h10, 1'b1, 32'h2222_2222, 1'b0);
        fetch(1, 32'h10, 1'b0, '0, 1'b0);

        // Reset during WAIT discards the request but keeps the array.
        rd_addr[0] = 32'h18;
        rd_en[0]   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rd_en[0] = 1'b0;
        @(negedge clk);
        check("rst_wait_ready", {31'b0, rdy[0]}, 32'd0);
        check("rst_wait_data", rdata[0], 32'd0);
        @(posedge clk);
        #1;
        fetch(0, 32'h18, 1'b0, '0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_write(($urandom_range(0, 7) == 0) ? addr_t'($urandom)
                                                     : addr_t'($urandom_range(0, DEPTH * 4 - 1)),
                         $urandom);
            end
            if ($urandom_range(0, 4) == 0) a = $urandom;
            else a = addr_t'($urandom_range(0, DEPTH * 4 - 1));
            fetch($urandom_range(0, 1), a, 1'b0, '0, $urandom_range(0, 1) == 1);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
